// File: rtl/sd_dat_tx_if.sv
// Signals between the SD DAT0 block transmitter, the host write buffer, the pad driver and the CRC16 unit.
// slave is the transmitter's view; master is the view of whatever surrounds it.
interface sd_dat_tx_if;
  logic        start;
  logic        abort;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic        datOut;
  logic        datOe;
  logic        busy;
  logic        done;
  logic        underrun;
  logic        crcBit;
  logic        crcEn;
  logic        crcRst;
  logic [15:0] crcVal;

  modport slave (
    input  start, abort, txData, txValid, crcVal,
    output txReady, datOut, datOe, busy, done, underrun, crcBit, crcEn, crcRst
  );

  modport master (
    output start, abort, txData, txValid, crcVal,
    input  txReady, datOut, datOe, busy, done, underrun, crcBit, crcEn, crcRst
  );
endinterface

// File: rtl/sd_dat_tx.sv
// Serialises one SD block on DAT0: start bit, BLK_BYTES bytes MSB-first, 16-bit CRC from the external unit, end bit.
// The bus clock never stalls: a byte missing at its load slot goes out as 8'hFF and sets the sticky underrun flag.
module sd_dat_tx #(
  parameter int BLK_BYTES = 512,
  parameter int CNT_W     = 10
) (
  input logic        sdClk,
  input logic        sdRst_n,
  sd_dat_tx_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_END, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLK_BYTES - 1);

  state_t           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [CNT_W-1:0] byteCnt_q, byteCnt_d;
  logic [3:0]       idx_q, idx_d;
  logic             underrun_q, underrun_d;
  logic             crcRst_q, crcRst_d;
  logic             last_byte;
  logic             load_byte;

  assign last_byte = (byteCnt_q == LAST_BYTE);
  assign load_byte = (state_q == S_START) ||
                     (state_q == S_DATA && bitCnt_q == 3'd0 && !last_byte);

  always_ff @(posedge sdClk or negedge sdRst_n) begin
    if (!sdRst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= 8'hFF;
      bitCnt_q   <= 3'd7;
      byteCnt_q  <= '0;
      idx_q      <= '0;
      underrun_q <= 1'b0;
      crcRst_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitCnt_q   <= bitCnt_d;
      byteCnt_q  <= byteCnt_d;
      idx_q      <= idx_d;
      underrun_q <= underrun_d;
      crcRst_q   <= crcRst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitCnt_d   = bitCnt_q;
    byteCnt_d  = byteCnt_q;
    idx_d      = idx_q;
    underrun_d = underrun_q;
    crcRst_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_START;
          crcRst_d   = 1'b1;
          underrun_d = 1'b0;
        end
      end
      S_START: begin
        state_d   = S_DATA;
        bitCnt_d  = 3'd7;
        byteCnt_d = '0;
      end
      S_DATA: begin
        shreg_d  = {shreg_q[6:0], 1'b0};
        bitCnt_d = bitCnt_q - 3'd1;
        if (bitCnt_q == 3'd0) begin
          if (last_byte) begin
            state_d = S_CRC;
            idx_d   = '0;
          end else begin
            byteCnt_d = byteCnt_q + CNT_W'(1);
          end
        end
      end
      S_CRC: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = S_END;
      end
      S_END:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The substituted 8'hFF is really transmitted, so the CRC unit sees it too.
    if (load_byte) begin
      shreg_d = bus.txValid ? bus.txData : 8'hFF;
      if (!bus.txValid) underrun_d = 1'b1;
    end
    if (bus.abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_comb begin
    bus.datOut  = 1'b1;
    bus.datOe   = 1'b0;
    bus.busy    = 1'b1;
    bus.done    = 1'b0;
    bus.txReady = 1'b0;
    bus.crcEn   = 1'b0;
    case (state_q)
      S_IDLE: bus.busy = 1'b0;
      S_START: begin
        bus.datOe   = 1'b1;
        bus.datOut  = 1'b0;
        bus.txReady = 1'b1;
      end
      S_DATA: begin
        bus.datOe   = 1'b1;
        bus.datOut  = shreg_q[7];
        bus.crcEn   = 1'b1;
        bus.txReady = (bitCnt_q == 3'd0) && !last_byte;
      end
      // crcEn is low here, so crcVal holds the finished checksum.
      S_CRC: begin
        bus.datOe  = 1'b1;
        bus.datOut = bus.crcVal[4'd15 - idx_q];
      end
      S_END:   bus.datOe = 1'b1;
      S_DONE:  bus.done  = 1'b1;
      default: bus.busy  = 1'b0;
    endcase
  end

  assign bus.crcBit   = bus.datOut;
  assign bus.crcRst   = crcRst_q;
  assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_sd_dat_tx.sv
// Bench for sd_dat_tx: a 4-byte instance for most scenarios and a 512-byte instance for the all-0xFF known answer.
// Expected frames come from a polynomial-division CRC model of the bytes that should appear on the line.
`timescale 1ns/1ps
module tb_sd_dat_tx;
  typedef logic       bitq_t[$];
  typedef logic [7:0] byteq_t[$];

  localparam int SB  = 4;
  localparam int BIG = 512;

  logic sdClk   = 1'b0;
  logic sdRst_n = 1'b0;
  always #5 sdClk = ~sdClk;

  logic       start_r   = 1'b0;
  logic       abort_r   = 1'b0;
  logic [7:0] txData_r  = 8'h00;
  logic       txValid_r = 1'b0;
  logic       sel       = 1'b0;

  sd_dat_tx_if sb ();
  sd_dat_tx_if bb ();

  assign sb.start   = start_r & ~sel;
  assign bb.start   = start_r & sel;
  assign sb.abort   = abort_r;
  assign bb.abort   = abort_r;
  assign sb.txData  = txData_r;
  assign bb.txData  = txData_r;
  assign sb.txValid = txValid_r;
  assign bb.txValid = txValid_r;

  sd_dat_tx #(.BLK_BYTES(SB), .CNT_W(2)) u_dut (.sdClk(sdClk), .sdRst_n(sdRst_n), .bus(sb));
  sd_dat_tx #(.BLK_BYTES(BIG), .CNT_W(9)) u_big (.sdClk(sdClk), .sdRst_n(sdRst_n), .bus(bb));

  // External SD_CRC16 units: serial CCITT CRC, synchronous clear.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [15:0] n;
    n = {c[14:0], 1'b0};
    if (c[15] ^ b) n = n ^ 16'h1021;
    return n;
  endfunction

  logic [15:0] crc_s, crc_b;
  always_ff @(posedge sdClk) begin
    if (sb.crcRst)     crc_s <= 16'h0000;
    else if (sb.crcEn) crc_s <= crc_step(crc_s, sb.crcBit);
    if (bb.crcRst)     crc_b <= 16'h0000;
    else if (bb.crcEn) crc_b <= crc_step(crc_b, bb.crcBit);
  end
  assign sb.crcVal = crc_s;
  assign bb.crcVal = crc_b;

  wire m_datOut   = sel ? bb.datOut   : sb.datOut;
  wire m_datOe    = sel ? bb.datOe    : sb.datOe;
  wire m_busy     = sel ? bb.busy     : sb.busy;
  wire m_done     = sel ? bb.done     : sb.done;
  wire m_underrun = sel ? bb.underrun : sb.underrun;
  wire m_txReady  = sel ? bb.txReady  : sb.txReady;
  wire m_crcBit   = sel ? bb.crcBit   : sb.crcBit;
  wire m_crcEn    = sel ? bb.crcEn    : sb.crcEn;
  wire m_crcRst   = sel ? bb.crcRst   : sb.crcRst;

  int tot = 0;
  int bad = 0;

  // ---------------- reference model ----------------
  function automatic logic [15:0] crc16_of(input byteq_t s);
    logic [16:0] r;
    logic        b;
    r = '0;
    for (int i = 0; i < s.size() + 2; i++)
      for (int j = 7; j >= 0; j--) begin
        b = (i < s.size()) ? s[i][j] : 1'b0;
        r = {r[15:0], b};
        if (r[16]) r = r ^ 17'h11021;
      end
    return r[15:0];
  endfunction

  function automatic bitq_t build_frame(input byteq_t s);
    bitq_t       f;
    logic [15:0] c;
    f.push_back(1'b0);
    foreach (s[i]) for (int j = 7; j >= 0; j--) f.push_back(s[i][j]);
    c = crc16_of(s);
    for (int j = 15; j >= 0; j--) f.push_back(c[j]);
    f.push_back(1'b1);
    return f;
  endfunction

  function automatic byteq_t sent_bytes(input byteq_t d, input int drop);
    byteq_t r;
    r = d;
    if (drop >= 0 && drop < r.size()) r[drop] = 8'hFF;
    return r;
  endfunction

  function automatic int frame_diff(input bitq_t a, input bitq_t b);
    int n;
    n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) n++;
    return n;
  endfunction

  function automatic logic [15:0] field_crc(input bitq_t g, input int nb);
    logic [15:0] c;
    c = 'x;
    if (g.size() >= 8 * nb + 17)
      for (int j = 0; j < 16; j++) c[15 - j] = g[8 * nb + 1 + j];
    return c;
  endfunction

  // ---------------- block driver / capture ----------------
  byteq_t blk_q;
  bitq_t  got;
  int     n_drv, done_cyc, n_hs, n_crcen, n_crcbit_bad;
  logic   rst_at_start, oe_at_start;
  bit     timed_out;

  task automatic run_block(input int drop, input bit pulse_mid);
    int   idx;
    logic hs, hsv;
    got = {};
    n_drv = 0; done_cyc = 0; n_hs = 0; n_crcen = 0; n_crcbit_bad = 0;
    timed_out = 1'b1;
    idx = 0;
    @(posedge sdClk); #1;
    start_r   = 1'b1;
    txData_r  = blk_q[0];
    txValid_r = (drop != 0);
    @(posedge sdClk); #1;
    start_r = 1'b0;
    for (int cyc = 1; cyc <= 8 * BIG + 64; cyc++) begin
      @(negedge sdClk);
      if (cyc == 1) begin
        oe_at_start  = m_datOe;
        rst_at_start = m_crcRst;
      end
      if (m_datOe) begin
        got.push_back(m_datOut);
        n_drv++;
      end
      if (m_crcEn) n_crcen++;
      if (m_crcBit !== m_datOut) n_crcbit_bad++;
      if (m_done) begin
        done_cyc  = cyc;
        timed_out = 1'b0;
        break;
      end
      hs  = m_txReady;
      hsv = m_txReady & txValid_r;
      @(posedge sdClk); #1;
      if (hs) idx++;
      if (hsv) n_hs++;
      txData_r  = (idx < blk_q.size()) ? blk_q[idx] : 8'h00;
      txValid_r = (idx != drop);
      start_r   = pulse_mid && (cyc == 20);
    end
    start_r   = 1'b0;
    txValid_r = 1'b1;
  endtask

  task automatic rand_block(input int n);
    blk_q = {};
    for (int i = 0; i < n; i++) blk_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    repeat (2) @(posedge sdClk);
    #1;
    tot++; if (m_datOe !== 1'b0)   begin bad++; $display("FAIL rst_datOe got=%b want=0", m_datOe); end
    tot++; if (m_datOut !== 1'b1)  begin bad++; $display("FAIL rst_datOut got=%b want=1", m_datOut); end
    tot++; if (m_busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b want=0", m_busy); end
    tot++; if (m_done !== 1'b0)    begin bad++; $display("FAIL rst_done got=%b want=0", m_done); end
    tot++; if (m_underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun got=%b want=0", m_underrun); end
    tot++; if (m_txReady !== 1'b0) begin bad++; $display("FAIL rst_txReady got=%b want=0", m_txReady); end
    tot++; if (m_crcEn !== 1'b0)   begin bad++; $display("FAIL rst_crcEn got=%b want=0", m_crcEn); end
    tot++; if (m_crcRst !== 1'b1)  begin bad++; $display("FAIL rst_crcRst got=%b want=1", m_crcRst); end
    @(negedge sdClk);
    sdRst_n = 1'b1;
    #1;
    tot++; if (m_crcRst !== 1'b1) begin bad++; $display("FAIL rst_crcRst_first_cycle got=%b want=1", m_crcRst); end
    @(posedge sdClk); #1;
    tot++; if (m_crcRst !== 1'b0) begin bad++; $display("FAIL rst_crcRst_after got=%b want=0", m_crcRst); end
  endtask

  task automatic test_zero_block;
    bitq_t exp;
    blk_q = {8'h00, 8'h00, 8'h00, 8'h00};
    exp   = build_frame(blk_q);
    run_block(-1, 1'b0);
    tot++; if (timed_out)          begin bad++; $display("FAIL zero_timeout got=1 want=0"); end
    tot++; if (n_drv != 8*SB+18)   begin bad++; $display("FAIL zero_drv_cycles got=%0d want=%0d", n_drv, 8*SB+18); end
    tot++; if (done_cyc != 8*SB+19) begin bad++; $display("FAIL zero_done_cycle got=%0d want=%0d", done_cyc, 8*SB+19); end
    tot++; if (frame_diff(exp, got) != 0) begin bad++; $display("FAIL zero_frame diff=%0d want=0", frame_diff(exp, got)); end
    tot++; if (field_crc(got, SB) !== 16'h0000) begin bad++; $display("FAIL zero_crc got=%h want=0000", field_crc(got, SB)); end
    tot++; if (m_underrun !== 1'b0) begin bad++; $display("FAIL zero_underrun got=%b want=0", m_underrun); end
    tot++; if (rst_at_start !== 1'b1) begin bad++; $display("FAIL zero_crcRst_start got=%b want=1", rst_at_start); end
    tot++; if (n_crcen != 8*SB)    begin bad++; $display("FAIL zero_crcEn_cycles got=%0d want=%0d", n_crcen, 8*SB); end
    tot++; if (n_crcbit_bad != 0)  begin bad++; $display("FAIL zero_crcBit_eq got=%0d want=0", n_crcbit_bad); end
    tot++; if (n_hs != SB)         begin bad++; $display("FAIL zero_handshakes got=%0d want=%0d", n_hs, SB); end
  endtask

  // Consecutive blocks: each new start lands in the IDLE cycle right after DONE.
  task automatic test_back_to_back;
    bitq_t exp;
    for (int k = 0; k < 4; k++) begin
      rand_block(SB);
      exp = build_frame(blk_q);
      run_block(-1, 1'b0);
      tot++; if (oe_at_start !== 1'b1) begin bad++; $display("FAIL b2b_start_next_cycle blk=%0d got=%b want=1", k, oe_at_start); end
      tot++; if (frame_diff(exp, got) != 0) begin bad++; $display("FAIL b2b_frame blk=%0d diff=%0d want=0", k, frame_diff(exp, got)); end
      tot++; if (field_crc(got, SB) !== crc16_of(blk_q)) begin bad++; $display("FAIL b2b_crc blk=%0d got=%h want=%h", k, field_crc(got, SB), crc16_of(blk_q)); end
      tot++; if (n_hs != SB) begin bad++; $display("FAIL b2b_handshakes blk=%0d got=%0d want=%0d", k, n_hs, SB); end
    end
  endtask

  task automatic test_underrun;
    bitq_t exp;
    rand_block(SB);
    exp = build_frame(sent_bytes(blk_q, 2));
    run_block(2, 1'b0);
    tot++; if (frame_diff(exp, got) != 0) begin bad++; $display("FAIL urun_frame diff=%0d want=0", frame_diff(exp, got)); end
    tot++; if (field_crc(got, SB) !== crc16_of(sent_bytes(blk_q, 2))) begin bad++; $display("FAIL urun_crc got=%h want=%h", field_crc(got, SB), crc16_of(sent_bytes(blk_q, 2))); end
    tot++; if (n_hs != SB-1) begin bad++; $display("FAIL urun_handshakes got=%0d want=%0d", n_hs, SB-1); end
    tot++; if (m_underrun !== 1'b1) begin bad++; $display("FAIL urun_flag got=%b want=1", m_underrun); end
    repeat (5) @(negedge sdClk);
    tot++; if (m_underrun !== 1'b1) begin bad++; $display("FAIL urun_sticky got=%b want=1", m_underrun); end
    rand_block(SB);
    exp = build_frame(blk_q);
    run_block(-1, 1'b0);
    tot++; if (m_underrun !== 1'b0) begin bad++; $display("FAIL urun_cleared got=%b want=0", m_underrun); end
    tot++; if (frame_diff(exp, got) != 0) begin bad++; $display("FAIL urun_next_frame diff=%0d want=0", frame_diff(exp, got)); end
  endtask

  task automatic test_start_ignored;
    bitq_t exp;
    rand_block(SB);
    exp = build_frame(sent_bytes(blk_q, 1));
    run_block(1, 1'b1);
    tot++; if (frame_diff(exp, got) != 0) begin bad++; $display("FAIL midstart_frame diff=%0d want=0", frame_diff(exp, got)); end
    tot++; if (n_drv != 8*SB+18) begin bad++; $display("FAIL midstart_drv got=%0d want=%0d", n_drv, 8*SB+18); end
    tot++; if (m_underrun !== 1'b1) begin bad++; $display("FAIL midstart_underrun got=%b want=1", m_underrun); end
    @(negedge sdClk);
    tot++; if (m_busy !== 1'b0) begin bad++; $display("FAIL midstart_no_restart got=%b want=0", m_busy); end
  endtask

  task automatic test_abort;
    bitq_t exp;
    int    ndone;
    rand_block(SB);
    @(posedge sdClk); #1;
    start_r = 1'b1; txData_r = blk_q[0]; txValid_r = 1'b1;
    @(posedge sdClk); #1;
    start_r = 1'b0;
    repeat (13) @(posedge sdClk);
    #1;
    tot++; if (m_busy !== 1'b1 || m_datOe !== 1'b1) begin bad++; $display("FAIL abort_pre busy=%b oe=%b want=1,1", m_busy, m_datOe); end
    abort_r = 1'b1;
    @(posedge sdClk); #1;
    abort_r = 1'b0;
    tot++; if (m_datOe !== 1'b0) begin bad++; $display("FAIL abort_datOe got=%b want=0", m_datOe); end
    tot++; if (m_busy !== 1'b0)  begin bad++; $display("FAIL abort_busy got=%b want=0", m_busy); end
    ndone = 0;
    repeat (10) begin
      @(negedge sdClk);
      if (m_done) ndone++;
    end
    tot++; if (ndone != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", ndone); end
    blk_q = {8'hA5, 8'hA5, 8'hA5, 8'hA5};
    exp   = build_frame(blk_q);
    run_block(-1, 1'b0);
    tot++; if (frame_diff(exp, got) != 0) begin bad++; $display("FAIL abort_next_frame diff=%0d want=0", frame_diff(exp, got)); end
    tot++; if (field_crc(got, SB) !== crc16_of(blk_q)) begin bad++; $display("FAIL abort_next_crc got=%h want=%h", field_crc(got, SB), crc16_of(blk_q)); end
  endtask

  task automatic test_async_reset;
    bitq_t exp;
    rand_block(SB);
    @(posedge sdClk); #1;
    start_r = 1'b1; txData_r = blk_q[0]; txValid_r = 1'b1;
    @(posedge sdClk); #1;
    start_r = 1'b0;
    repeat (39) @(posedge sdClk);
    #1;
    tot++; if (m_datOe !== 1'b1 || m_crcEn !== 1'b0) begin bad++; $display("FAIL areset_in_crc oe=%b en=%b want=1,0", m_datOe, m_crcEn); end
    #2;
    sdRst_n = 1'b0;
    #1;
    tot++; if (m_datOe !== 1'b0)  begin bad++; $display("FAIL areset_datOe got=%b want=0", m_datOe); end
    tot++; if (m_datOut !== 1'b1) begin bad++; $display("FAIL areset_datOut got=%b want=1", m_datOut); end
    tot++; if (m_crcRst !== 1'b1) begin bad++; $display("FAIL areset_crcRst got=%b want=1", m_crcRst); end
    tot++; if (m_busy !== 1'b0)   begin bad++; $display("FAIL areset_busy got=%b want=0", m_busy); end
    @(negedge sdClk);
    sdRst_n = 1'b1;
    rand_block(SB);
    exp = build_frame(blk_q);
    run_block(-1, 1'b0);
    tot++; if (frame_diff(exp, got) != 0) begin bad++; $display("FAIL areset_recover_frame diff=%0d want=0", frame_diff(exp, got)); end
  endtask

  task automatic test_known_answer;
    bitq_t exp;
    sel   = 1'b1;
    blk_q = {};
    for (int i = 0; i < BIG; i++) blk_q.push_back(8'hFF);
    exp = build_frame(blk_q);
    run_block(-1, 1'b0);
    tot++; if (timed_out) begin bad++; $display("FAIL ka_timeout got=1 want=0"); end
    tot++; if (n_drv != 8*BIG+18) begin bad++; $display("FAIL ka_drv got=%0d want=%0d", n_drv, 8*BIG+18); end
    tot++; if (n_hs != BIG) begin bad++; $display("FAIL ka_handshakes got=%0d want=%0d", n_hs, BIG); end
    tot++; if (field_crc(got, BIG) !== 16'h7FA1) begin bad++; $display("FAIL ka_crc got=%h want=7fa1", field_crc(got, BIG)); end
    tot++; if (frame_diff(exp, got) != 0) begin bad++; $display("FAIL ka_frame diff=%0d want=0", frame_diff(exp, got)); end
    tot++; if (done_cyc != 8*BIG+19) begin bad++; $display("FAIL ka_done_cycle got=%0d want=%0d", done_cyc, 8*BIG+19); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_zero_block;
    test_back_to_back;
    test_underrun;
    test_start_ignored;
    test_abort;
    test_async_reset;
    test_known_answer;
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
